seq_multiplier16: RTL and testbench
===================================

# seq_multiplier16

Sequential 16×16 shift-and-add multiplier with a Load/Done handshake. It is the multiply-side counterpart to the datapath's iterative divider and shares its control style: operands are latched on Load, one multiplier bit is retired per clock, and Done with a 32-bit product follows. The CPU datapath uses it for MUL-class instructions, with the ACC/MDR values as operands.

## Interface
Parameters: none.

- Clk — input, 1 — rising-edge clock; the only clock.
- Reset — input, 1 — synchronous, active-high; overrides all other inputs.
- A — input, 16 — multiplicand; sampled only on the accepting edge.
- B — input, 16 — multiplier; sampled only on the accepting edge.
- Load — input, 1 — start request; level-sampled every edge.
- P — output, 32 — product; registered; holds its value until the next accepted Load or Reset.
- Done — output, 1 — registered; high when P is valid.
- Busy — output, 1 — registered; high while an operation is in flight.

## Operation
- States: IDLE, CALC.
- IDLE with Load=1 at an edge (the accept):
  - latch the A and B operands (or their magnitudes, see Configuration);
  - ACC=0, count=0, Done=0, Busy=1, P unchanged; next state CALC.
- IDLE with Load=0: hold all outputs.
- CALC, each edge:
  - 17-bit sum = {0,ACC} + (MPLR[0] ? {0,MCAND} : 0);
  - {ACC,MPLR} = {sum,MPLR} >> 1 (33-bit shift, carry enters bit 31);
  - count++.
- CALC, edge where count==15 (the 16th iteration):
  - P = final {ACC,MPLR};
  - Done=1, Busy=0; next state IDLE.
- Load while in CALC is ignored. The operation in flight is not disturbed.
- Changes on A or B after the accept have no effect.
- Arithmetic is unsigned modulo-free: the 32-bit P always holds the exact product. For example, 0xFFFF×0xFFFF = 0xFFFE0001.
- A zero operand still takes the full 16 iterations. There is no early exit.

## Timing
- Reset values: P=0x00000000, Done=0, Busy=0, state=IDLE, count=0, ACC=0.
- Reset takes priority over Load on the same edge.
- Reset mid-CALC aborts the operation. Outputs take their reset values on that edge.
- Latency: with the accept at edge N, Busy=1 after edge N and Done=1 after edge N+16. P is valid in the same cycle that Done rises.
- Done stays high until the next accepted Load or Reset.
- Load held high continuously: a new accept occurs at edge N+17. Done is therefore high for exactly one cycle, and the old P stays visible during that cycle.
- Busy and Done are never both high.
- Throughput: one product per 17 cycles when back-to-back.

## Configuration
Macro: MUL_SIGNED_EN.

- Defined — operands are two's complement:
  - at the accept, MCAND=|A| and MPLR=|B|, each as 16-bit unsigned (|0x8000| = 0x8000);
  - the latched sign is A[15]^B[15];
  - on the final edge, P is the 32-bit two's-complement negation of the magnitude product if the sign is 1.
  - Latency is unchanged.
- Undefined: unsigned operation only. No sign logic is present.

## Test plan
- Basic: Reset 2 cycles, then A=0x0003, B=0x0005, Load for 1 cycle → Busy high 16 cycles; Done=1 and P=0x0000000F after accept+16.
- Width extremes:
  - unsigned build: A=B=0xFFFF → P=0xFFFE0001;
  - MUL_SIGNED_EN build: same operands → P=0x00000001.
- Signed build only:
  - A=0x8000, B=0x8000 → P=0x40000000;
  - A=0xFFFD, B=0x0007 → P=0xFFFFFFEB.
  - The same A=0xFFFD, B=0x0007 in the unsigned build → P=0x0006FFEB.
- Ignored Load: accept A=0x0010, B=0x0010; at accept+5 pulse Load with A=0x1234, B=0x0002 → P=0x00000100 at accept+16, with no second operation started.
- Reset mid-op: accept A=0x00FF, B=0x00FF; assert Reset at accept+8 → P=0, Done=0, Busy=0. A following accept of A=0x0002, B=0x0000 → P=0 and Done at +16.
- Back-to-back: Load held high with A=0x0007, B=0x0006 → Done pulses for exactly 1 cycle every 17 cycles, P=0x0000002A each time, and Busy/Done are never high together.

Source files
------------

// File: rtl/seq_multiplier16_if.sv
// seq_multiplier16_if
// Handshake/operand bundle for the sequential 16x16 multiplier.
//   a, b  : 16-bit operands, sampled on the accepting edge only
//   load  : start request, level-sampled every edge
//   p     : 32-bit registered product
//   done  : registered, high while p holds a valid product
//   busy  : registered, high while a multiplication is in flight
// Modports: master drives operands/load; slave (the multiplier) drives results.
interface seq_multiplier16_if;
  logic [15:0] a;
  logic [15:0] b;
  logic        load;
  logic [31:0] p;
  logic        done;
  logic        busy;

  modport master (output a, output b, output load,
                  input  p, input  done, input  busy);
  modport slave  (input  a, input  b, input  load,
                  output p, output done, output busy);
endinterface

// File: rtl/seq_multiplier16.sv
// seq_multiplier16
// Sequential 16x16 shift-and-add multiplier with a load/done handshake.
// One multiplier bit is retired per clock; the product appears 16 edges
// after the accepting edge, with done raised in the same cycle.
// Ports:
//   clk   : rising-edge clock
//   Reset : synchronous, active-high; overrides every other input
//   bus   : seq_multiplier16_if.slave (a, b, load in; p, done, busy out)
// Optional feature: define MUL_SIGNED_EN for two's-complement operands
// (magnitudes are multiplied and the product negated when signs differ).
// Without the macro the block is unsigned only and carries no sign logic.
module seq_multiplier16 (
  input  logic                 clk,
  input  logic                 Reset,
  seq_multiplier16_if.slave    bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_t;

  state_t      state_r;
  logic [15:0] acc_r;
  logic [15:0] mplr_r;
  logic [15:0] mcand_r;
  logic [3:0]  count_r;
  logic [31:0] p_r;
  logic        done_r;
  logic        busy_r;

  logic [16:0] sum_s;
  logic [31:0] prod_s;
  logic [31:0] result_s;
  logic [15:0] mcand_in_s;
  logic [15:0] mplr_in_s;

`ifdef MUL_SIGNED_EN
  logic        sign_r;

  // Two's-complement magnitude as unsigned; 0x8000 maps to itself.
  function automatic logic [15:0] mag16(input logic [15:0] v);
    if (v[15]) begin
      mag16 = 16'd0 - v;
    end else begin
      mag16 = v;
    end
  endfunction
`endif

  // Operand conditioning at accept time (magnitudes in the signed build).
  always_comb begin
`ifdef MUL_SIGNED_EN
    mcand_in_s = mag16(bus.a);
    mplr_in_s  = mag16(bus.b);
`else
    mcand_in_s = bus.a;
    mplr_in_s  = bus.b;
`endif
  end

  // One shift-and-add step; the carry out of the add lands in bit 31
  // of the shifted {acc, mplr} pair.
  always_comb begin
    sum_s    = 17'd0;
    prod_s   = 32'd0;
    result_s = 32'd0;
    if (mplr_r[0]) begin
      sum_s = {1'b0, acc_r} + {1'b0, mcand_r};
    end else begin
      sum_s = {1'b0, acc_r};
    end
    prod_s = {sum_s, mplr_r[15:1]};
`ifdef MUL_SIGNED_EN
    if (sign_r) begin
      result_s = 32'd0 - prod_s;
    end else begin
      result_s = prod_s;
    end
`else
    result_s = prod_s;
`endif
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      acc_r   <= 16'd0;
      mplr_r  <= 16'd0;
      mcand_r <= 16'd0;
      count_r <= 4'd0;
      p_r     <= 32'd0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
`ifdef MUL_SIGNED_EN
      sign_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.load) begin
            mcand_r <= mcand_in_s;
            mplr_r  <= mplr_in_s;
            acc_r   <= 16'd0;
            count_r <= 4'd0;
            done_r  <= 1'b0;
            busy_r  <= 1'b1;
`ifdef MUL_SIGNED_EN
            sign_r  <= bus.a[15] ^ bus.b[15];
`endif
            state_r <= ST_CALC;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CALC: begin
          // load is deliberately ignored here; the operation runs to completion
          acc_r   <= prod_s[31:16];
          mplr_r  <= prod_s[15:0];
          count_r <= count_r + 4'd1;
          if (count_r == 4'd15) begin
            p_r     <= result_s;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_CALC;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.p    = p_r;
  assign bus.done = done_r;
  assign bus.busy = busy_r;

endmodule

// File: tb/tb_seq_multiplier16.sv
// tb_seq_multiplier16
// Directed bench for seq_multiplier16: reset state, basic products, width
// extremes, ignored load, reset mid-operation and back-to-back operation.
// Inputs change and outputs are sampled on the falling edge.
module tb_seq_multiplier16;

  logic clk;
  logic Reset;
  int   errors;
  int   checks;

  seq_multiplier16_if mul_if ();

  seq_multiplier16 dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (mul_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Full operation: accept at edge N, check busy through N+15, result at N+16.
  task automatic do_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp);
    mul_if.a    = a;
    mul_if.b    = b;
    mul_if.load = 1'b1;
    @(negedge clk);
    mul_if.load = 1'b0;
    mul_if.a    = 16'hA5A5;
    mul_if.b    = 16'h5A5A;
    check({tag, "_busy_start"}, {31'd0, mul_if.busy}, 32'd1);
    check({tag, "_done_start"}, {31'd0, mul_if.done}, 32'd0);
    repeat (15) @(negedge clk);
    check({tag, "_busy_n15"}, {31'd0, mul_if.busy}, 32'd1);
    check({tag, "_done_n15"}, {31'd0, mul_if.done}, 32'd0);
    @(negedge clk);
    check({tag, "_done"}, {31'd0, mul_if.done}, 32'd1);
    check({tag, "_busy_end"}, {31'd0, mul_if.busy}, 32'd0);
    check({tag, "_p"}, mul_if.p, exp);
  endtask

  initial begin
    int done_pulses;
    errors      = 0;
    checks      = 0;
    Reset       = 1'b1;
    mul_if.a    = 16'd0;
    mul_if.b    = 16'd0;
    mul_if.load = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_p", mul_if.p, 32'd0);
    check("rst_done", {31'd0, mul_if.done}, 32'd0);
    check("rst_busy", {31'd0, mul_if.busy}, 32'd0);
    Reset = 1'b0;
    @(negedge clk);

    do_mul("basic", 16'h0003, 16'h0005, 32'h0000_000F);
    // Done must hold while idle.
    repeat (3) @(negedge clk);
    check("basic_done_hold", {31'd0, mul_if.done}, 32'd1);
    check("basic_p_hold", mul_if.p, 32'h0000_000F);

`ifdef MUL_SIGNED_EN
    do_mul("ffff", 16'hFFFF, 16'hFFFF, 32'h0000_0001);
    do_mul("neg7", 16'hFFFD, 16'h0007, 32'hFFFF_FFEB);
`else
    do_mul("ffff", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
    do_mul("neg7", 16'hFFFD, 16'h0007, 32'h0006_FFEB);
`endif
    do_mul("m8000", 16'h8000, 16'h8000, 32'h4000_0000);
    do_mul("zero", 16'h0000, 16'h1234, 32'h0000_0000);

    // Ignored load: pulse at accept+5 with different operands.
    mul_if.a    = 16'h0010;
    mul_if.b    = 16'h0010;
    mul_if.load = 1'b1;
    @(negedge clk);                 // after edge N
    mul_if.load = 1'b0;
    repeat (4) @(negedge clk);      // after edge N+4
    mul_if.a    = 16'h1234;
    mul_if.b    = 16'h0002;
    mul_if.load = 1'b1;
    @(negedge clk);                 // after edge N+5
    mul_if.load = 1'b0;
    check("ign_busy_mid", {31'd0, mul_if.busy}, 32'd1);
    repeat (11) @(negedge clk);     // after edge N+16
    check("ign_done", {31'd0, mul_if.done}, 32'd1);
    check("ign_p", mul_if.p, 32'h0000_0100);
    repeat (3) @(negedge clk);
    check("ign_no_restart", {31'd0, mul_if.busy}, 32'd0);
    check("ign_done_hold", {31'd0, mul_if.done}, 32'd1);

    // Reset mid-operation at accept+8.
    mul_if.a    = 16'h00FF;
    mul_if.b    = 16'h00FF;
    mul_if.load = 1'b1;
    @(negedge clk);
    mul_if.load = 1'b0;
    repeat (7) @(negedge clk);      // after edge N+7
    Reset = 1'b1;
    mul_if.load = 1'b1;             // reset wins over load
    @(negedge clk);
    Reset = 1'b0;
    mul_if.load = 1'b0;
    check("midrst_p", mul_if.p, 32'd0);
    check("midrst_done", {31'd0, mul_if.done}, 32'd0);
    check("midrst_busy", {31'd0, mul_if.busy}, 32'd0);
    do_mul("after_rst", 16'h0002, 16'h0000, 32'h0000_0000);

    // Back-to-back with load held high: accepts at N, N+17, N+34.
    done_pulses = 0;
    mul_if.a    = 16'h0007;
    mul_if.b    = 16'h0006;
    mul_if.load = 1'b1;
    @(negedge clk);                 // after edge N
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);               // after edge N+k
      if (k == 50) mul_if.load = 1'b0;
      if (mul_if.busy && mul_if.done) begin
        check("b2b_overlap", 32'd1, 32'd0);
      end
      if ((k % 17) == 16) begin
        check("b2b_done", {31'd0, mul_if.done}, 32'd1);
        check("b2b_p", mul_if.p, 32'h0000_002A);
      end else begin
        check("b2b_busy", {31'd0, mul_if.busy}, 32'd1);
      end
      if (mul_if.done) done_pulses++;
    end
    check("b2b_pulses", done_pulses, 32'd3);
    @(negedge clk);
    check("b2b_idle", {31'd0, mul_if.busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
